// File: rtl/fft_pkg.sv
// Shared FFT constants, FSM state type and index bit-reversal helper.
package fft_pkg;

  localparam int N_POINTS = 16;
  localparam int LOG2_N   = 4;
  localparam int DATA_W   = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  // Reverse the bit order of an LOG2_N-bit index.
  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] idx);
    logic [LOG2_N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2_N; b++) begin
      r[b] = idx[LOG2_N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Combinational index reverser: rev is idx with its bit order mirrored.
module fft_bitrev #(
  parameter int WIDTH = fft_pkg::LOG2_N
) (
  input  logic [WIDTH-1:0] idx,
  output logic [WIDTH-1:0] rev
);

  // One wire per bit, mirrored around the centre of the index.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign rev[gi] = idx[WIDTH-1-gi];
  end

endmodule

// File: rtl/fft_result_reorder.sv
// Captures one bit-reversed FFT result frame and replays it in natural bin
// order over a valid/ready stream. Input is refused while a frame drains.
module fft_result_reorder #(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int LOG2_N   = fft_pkg::LOG2_N,
  parameter int DATA_W   = fft_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [LOG2_N-1:0] out_index,
  output logic              out_last,
  output logic              frame_done,
  output logic              drop_err
);
  import fft_pkg::*;

  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);

  state_t              state;
  logic [LOG2_N-1:0]   wr_cnt;
  logic [LOG2_N-1:0]   rd_ptr;
  logic [LOG2_N-1:0]   wr_addr;
  logic [2*DATA_W-1:0] buf_mem [N_POINTS];
  logic [2*DATA_W-1:0] rd_word;
  logic                out_valid_reg;
  logic                frame_done_reg;
  logic                drop_err_reg;
  logic                accept;
  logic                fire;

  // The core emits results in bit-reversed order, so storing arrival k at
  // bitrev(k) leaves the buffer in natural order for a linear read-out.
  fft_bitrev #(.WIDTH(LOG2_N)) u_bitrev (
    .idx (wr_cnt),
    .rev (wr_addr)
  );

  assign in_ready = (state == COLLECT);
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid_reg && out_ready;

  // Frame buffer: cleared on reset, written only while collecting.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_POINTS; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (accept) begin
      buf_mem[wr_addr] <= {in_real, in_imag};
    end
  end

  // COLLECT/DRAIN sequencing with registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= COLLECT;
      wr_cnt         <= '0;
      rd_ptr         <= '0;
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      drop_err_reg   <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (in_valid && !in_ready) begin
        drop_err_reg <= 1'b1;
      end
      case (state)
        COLLECT: begin
          if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST_IDX) begin
              state         <= DRAIN;
              wr_cnt        <= '0;
              rd_ptr        <= '0;
              out_valid_reg <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == LAST_IDX) begin
              state          <= COLLECT;
              out_valid_reg  <= 1'b0;
              frame_done_reg <= 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Read-out is combinational at rd_ptr; data fields are zero while idle so
  // nothing half-collected leaks onto the output bus.
  assign rd_word    = buf_mem[rd_ptr];
  assign out_valid  = out_valid_reg;
  assign out_real   = out_valid_reg ? rd_word[2*DATA_W-1:DATA_W] : '0;
  assign out_imag   = out_valid_reg ? rd_word[DATA_W-1:0] : '0;
  assign out_index  = out_valid_reg ? rd_ptr : '0;
  assign out_last   = out_valid_reg && (rd_ptr == LAST_IDX);
  assign frame_done = frame_done_reg;
  assign drop_err   = drop_err_reg;

endmodule
